// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : lfsr_pkg                                                 |
// | Purpose   : FSM encodings, LFSR step function and default tap table  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package lfsr_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE    = 3'd0;
    localparam state_t c_SEED    = 3'd1;
    localparam state_t c_PROBE   = 3'd2;
    localparam state_t c_DECRYPT = 3'd3;
    localparam state_t c_PAD     = 3'd4;
    localparam state_t c_DONE    = 3'd5;

    // Entry k occupies bits [k*8 +: 8].
    localparam logic [63:0] c_DEFAULT_TAPS =
        {8'hF3, 8'hFA, 8'hB2, 8'hB4, 8'hB8, 8'hC6, 8'hD4, 8'hE1};

    // Width-generic: callers zero-extend to 32 bits and keep the low W bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] tap);
        return {s[30:0], ^(s & tap)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_decrypt_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : lfsr_decrypt_engine_if                                   |
// | Purpose   : single-port data memory bus between engine and dmem      |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
interface lfsr_decrypt_engine_if #(
    parameter int W      = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [W-1:0]      mem_wdata;
    logic [W-1:0]      mem_rdata;

    modport master (output mem_addr, output mem_wr_en, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_wr_en, input mem_wdata, output mem_rdata);
endinterface
`default_nettype wire

// File: rtl/lfsr_trial_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : lfsr_trial_bank                                          |
// | Purpose   : parallel trial LFSRs, one per candidate tap, with mask   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module lfsr_trial_bank
    import lfsr_pkg::*;
#(
    parameter int W        = 8,
    parameter int NUM_TAPS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_TAPS*W-1:0] taps,
    input  logic                  load,
    input  logic [W-1:0]          load_val,
    input  logic                  step,
    input  logic [W-1:0]          expect_val,
    output logic [NUM_TAPS-1:0]   mask_next
);
    logic [NUM_TAPS-1:0] mask_q;
    logic [NUM_TAPS-1:0] w_miss;

    for (genvar j = 0; j < NUM_TAPS; j++) begin : g_trial
        logic [W-1:0] trial_q;
        logic [W-1:0] trial_d;
        logic [W-1:0] w_stepped;

        assign w_stepped = W'(lfsr_step(32'(trial_q), 32'(taps[j*W +: W])));
        assign w_miss[j] = step && (w_stepped != expect_val);

        always_comb begin
            trial_d = trial_q;
            if (load)
                trial_d = load_val;
            else if (step)
                trial_d = w_stepped;
        end

        always_ff @(posedge clk) begin
            if (rst)
                trial_q <= '0;
            else
                trial_q <= trial_d;
        end
    end

    // A candidate, once eliminated, stays eliminated until the next load.
    assign mask_next = load ? '1 : (mask_q & ~w_miss);

    always_ff @(posedge clk) begin
        if (rst)
            mask_q <= '1;
        else
            mask_q <= mask_next;
    end
endmodule
`default_nettype wire

// File: rtl/lfsr_decrypt_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : lfsr_decrypt_engine                                      |
// | Purpose   : tap search, in-place LFSR decrypt, preamble strip, pad   |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module lfsr_decrypt_engine
    import lfsr_pkg::*;
#(
    parameter int             W         = 8,
    parameter int             ADDR_W    = 8,
    parameter int             MSG_LEN   = 64,
    parameter int             SRC_BASE  = 64,
    parameter int             DST_BASE  = 0,
    parameter int             NUM_TAPS  = 8,
    parameter int             PROBE_LEN = 8,
    parameter logic [W-1:0]   PREAMBLE  = 8'h20,
    parameter logic [W-1:0]   CMP_MASK  = 8'h7F,
    parameter int             MAX_STRIP = 25
) (
    input  logic                             clk,
    input  logic                             init,
    input  logic [NUM_TAPS*W-1:0]            taps_in,
    lfsr_decrypt_engine_if.master            mem,
    output logic                             done,
    output logic                             match_err,
    output logic [$clog2(NUM_TAPS)-1:0]      tap_idx,
    output logic [$clog2(MAX_STRIP+1)-1:0]   strip_ct
);
    localparam int CNT_W   = $clog2(MSG_LEN + 2);
    localparam int TAP_W   = $clog2(NUM_TAPS);
    localparam int STRIP_W = $clog2(MAX_STRIP + 1);

    localparam logic [CNT_W-1:0]   c_PROBE_LAST = CNT_W'(PROBE_LEN + 1);
    localparam logic [CNT_W-1:0]   c_MSG_LAST   = CNT_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0]   c_MSG_END    = CNT_W'(MSG_LEN);
    localparam logic [STRIP_W-1:0] c_STRIP_MAX  = STRIP_W'(MAX_STRIP);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [W-1:0]          lfsr_q, lfsr_d;
    logic [W-1:0]          seed_q, seed_d;
    logic                  strip_mode_q, strip_mode_d;
    logic                  phase_q, phase_d;
    logic [TAP_W-1:0]      tap_idx_q, tap_idx_d;
    logic                  match_err_q, match_err_d;
    logic [STRIP_W-1:0]    strip_ct_q, strip_ct_d;
    logic [NUM_TAPS*W-1:0] taps_q, taps_d;

    logic                  w_load, w_step;
    logic [NUM_TAPS-1:0]   w_mask_next;
    logic [TAP_W-1:0]      w_low_idx;
    logic [W-1:0]          w_expect, w_plain, w_tap;
    logic                  w_strip_hit;

    assign w_expect    = mem.mem_rdata ^ PREAMBLE;
    assign w_plain     = mem.mem_rdata ^ lfsr_q;
    assign w_tap       = taps_q[tap_idx_q*W +: W];
    assign w_strip_hit = strip_mode_q && (((w_plain ^ PREAMBLE) & CMP_MASK) == '0)
                         && (strip_ct_q < c_STRIP_MAX);

    lfsr_trial_bank #(.W(W), .NUM_TAPS(NUM_TAPS)) u_bank (
        .clk        (clk),
        .rst        (init),
        .taps       (taps_q),
        .load       (w_load),
        .load_val   (w_expect),
        .step       (w_step),
        .expect_val (w_expect),
        .mask_next  (w_mask_next)
    );

    always_comb begin
        w_low_idx = '0;
        for (int j = NUM_TAPS - 1; j >= 0; j--)
            if (w_mask_next[j])
                w_low_idx = TAP_W'(j);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        lfsr_d        = lfsr_q;
        seed_d        = seed_q;
        strip_mode_d  = strip_mode_q;
        phase_d       = phase_q;
        tap_idx_d     = tap_idx_q;
        match_err_d   = match_err_q;
        strip_ct_d    = strip_ct_q;
        taps_d        = taps_q;
        w_load        = 1'b0;
        w_step        = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wr_en = 1'b0;
        mem.mem_wdata = '0;

        case (state_q)
            c_IDLE: begin
                taps_d  = taps_in;
                state_d = c_SEED;
            end
            c_SEED: begin
                mem.mem_addr = ADDR_W'(SRC_BASE);
                cnt_d        = CNT_W'(1);
                state_d      = c_PROBE;
            end
            // Read data lags the address by one cycle, so PROBE runs one
            // cycle past the last read to score the final probe word.
            c_PROBE: begin
                if (cnt_q != c_PROBE_LAST)
                    mem.mem_addr = ADDR_W'(SRC_BASE) + ADDR_W'(cnt_q);
                if (cnt_q == CNT_W'(1)) begin
                    w_load = 1'b1;
                    seed_d = w_expect;
                end else begin
                    w_step = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_PROBE_LAST) begin
                    cnt_d = '0;
                    if (w_mask_next == '0) begin
                        match_err_d = 1'b1;
                        state_d     = c_DONE;
                    end else begin
                        tap_idx_d    = w_low_idx;
                        lfsr_d       = seed_q;
                        phase_d      = 1'b0;
                        strip_mode_d = 1'b1;
                        state_d      = c_DECRYPT;
                    end
                end
            end
            c_DECRYPT: begin
                if (!phase_q) begin
                    mem.mem_addr = ADDR_W'(SRC_BASE) + ADDR_W'(cnt_q);
                    phase_d      = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    lfsr_d  = W'(lfsr_step(32'(lfsr_q), 32'(w_tap)));
                    if (w_strip_hit) begin
                        strip_ct_d = strip_ct_q + 1'b1;
                    end else begin
                        strip_mode_d  = 1'b0;
                        mem.mem_addr  = ADDR_W'(DST_BASE) + ADDR_W'(wr_ptr_q);
                        mem.mem_wr_en = 1'b1;
                        mem.mem_wdata = w_plain;
                        wr_ptr_d      = wr_ptr_q + 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_MSG_LAST)
                        state_d = (wr_ptr_d == c_MSG_END) ? c_DONE : c_PAD;
                end
            end
            c_PAD: begin
                mem.mem_addr  = ADDR_W'(DST_BASE) + ADDR_W'(wr_ptr_q);
                mem.mem_wr_en = 1'b1;
                mem.mem_wdata = PREAMBLE;
                wr_ptr_d      = wr_ptr_q + 1'b1;
                if (wr_ptr_q == c_MSG_LAST)
                    state_d = c_DONE;
            end
            c_DONE: state_d = c_DONE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q      <= c_IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            lfsr_q       <= '0;
            seed_q       <= '0;
            strip_mode_q <= 1'b0;
            phase_q      <= 1'b0;
            tap_idx_q    <= '0;
            match_err_q  <= 1'b0;
            strip_ct_q   <= '0;
            taps_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            lfsr_q       <= lfsr_d;
            seed_q       <= seed_d;
            strip_mode_q <= strip_mode_d;
            phase_q      <= phase_d;
            tap_idx_q    <= tap_idx_d;
            match_err_q  <= match_err_d;
            strip_ct_q   <= strip_ct_d;
            taps_q       <= taps_d;
        end
    end

    assign done      = (state_q == c_DONE);
    assign match_err = match_err_q;
    assign tap_idx   = tap_idx_q;
    assign strip_ct  = strip_ct_q;
endmodule
`default_nettype wire

// File: tb/tb_lfsr_decrypt_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_lfsr_decrypt_engine                                   |
// | Purpose   : directed self-checking bench for lfsr_decrypt_engine     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_lfsr_decrypt_engine;
    import lfsr_pkg::*;

    logic        clk;
    logic        init_a, init_b;
    logic [63:0] taps_a, taps_b;
    logic        done_a, done_b, merr_a, merr_b;
    logic [2:0]  tidx_a, tidx_b;
    logic [4:0]  sct_a, sct_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] plain [64];

    int checks = 0;
    int errors = 0;
    int wr_cnt_a = 0;
    int order_viol_b = 0;
    logic [7:0] last_rd_b = 8'h00;

    lfsr_decrypt_engine_if #(.W(8), .ADDR_W(8)) bus_a ();
    lfsr_decrypt_engine_if #(.W(8), .ADDR_W(8)) bus_b ();

    lfsr_decrypt_engine dut_a (
        .clk(clk), .init(init_a), .taps_in(taps_a), .mem(bus_a),
        .done(done_a), .match_err(merr_a), .tap_idx(tidx_a), .strip_ct(sct_a)
    );

    lfsr_decrypt_engine #(.MSG_LEN(16), .SRC_BASE(0), .DST_BASE(0)) dut_b (
        .clk(clk), .init(init_b), .taps_in(taps_b), .mem(bus_b),
        .done(done_b), .match_err(merr_b), .tap_idx(tidx_b), .strip_ct(sct_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_a.mem_wr_en) begin
            mem_a[bus_a.mem_addr] = bus_a.mem_wdata;
            wr_cnt_a <= wr_cnt_a + 1;
        end
        bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    end

    // In-place run: each write must target an address already read.
    always @(posedge clk) begin
        if (bus_b.mem_wr_en) begin
            mem_b[bus_b.mem_addr] = bus_b.mem_wdata;
            if (bus_b.mem_addr > last_rd_b)
                order_viol_b <= order_viol_b + 1;
        end else begin
            last_rd_b <= bus_b.mem_addr;
        end
        bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] step8(input logic [7:0] s, input logic [7:0] t);
        return {s[6:0], ^(s & t)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_plain(input int npre, input logic [7:0] fill);
        for (int i = 0; i < 64; i++)
            plain[i] = (i < npre) ? 8'h20 : fill;
    endtask

    task automatic load_msg(input int which, input logic [7:0] tap, input logic [7:0] seed,
                            input int len, input int src, input int dst);
        logic [7:0] s;
        s = seed;
        for (int i = 0; i < len; i++) begin
            if (which == 0) mem_a[dst + i] = 8'hFF;
            else            mem_b[dst + i] = 8'hFF;
        end
        for (int i = 0; i < len; i++) begin
            if (which == 0) mem_a[src + i] = plain[i] ^ s;
            else            mem_b[src + i] = plain[i] ^ s;
            s = step8(s, tap);
        end
    endtask

    task automatic run_dut(input int which, output int cycles);
        if (which == 0) init_a = 1'b1; else init_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (which == 0) init_a = 1'b0; else init_b = 1'b0;
        cycles = 0;
        while (((which == 0) ? !done_a : !done_b) && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic set_hello();
        fill_plain(9, 8'h2E);
        plain[9]  = 8'h48;
        plain[10] = 8'h65;
        plain[11] = 8'h6C;
        plain[12] = 8'h6C;
        plain[13] = 8'h6F;
    endtask

    task automatic check_hello(input string tag, input int cycles);
        check({tag, " cycles"}, cycles, 148);
        check({tag, " tap_idx"}, tidx_a, 3);
        check({tag, " match_err"}, merr_a, 0);
        check({tag, " strip_ct"}, sct_a, 9);
        check({tag, " dst0"}, mem_a[0], 8'h48);
        check({tag, " dst1"}, mem_a[1], 8'h65);
        check({tag, " dst2"}, mem_a[2], 8'h6C);
        check({tag, " dst3"}, mem_a[3], 8'h6C);
        check({tag, " dst4"}, mem_a[4], 8'h6F);
        check({tag, " dst5"}, mem_a[5], 8'h2E);
        check({tag, " dst54"}, mem_a[54], 8'h2E);
        check({tag, " dst55"}, mem_a[55], 8'h20);
        check({tag, " dst63"}, mem_a[63], 8'h20);
    endtask

    initial begin
        int cyc;
        int wr0;

        init_a = 1'b1;
        init_b = 1'b1;
        taps_a = c_DEFAULT_TAPS;
        taps_b = c_DEFAULT_TAPS;
        repeat (3) @(posedge clk);
        #1;
        check("rst done", done_a, 0);
        check("rst match_err", merr_a, 0);
        check("rst tap_idx", tidx_a, 0);
        check("rst strip_ct", sct_a, 0);
        check("rst wr_en", bus_a.mem_wr_en, 0);
        check("rst addr", bus_a.mem_addr, 0);

        // Hello, tap B8, seed 01
        set_hello();
        load_msg(0, 8'hB8, 8'h01, 64, 64, 0);
        run_dut(0, cyc);
        check_hello("hello", cyc);
        repeat (5) @(posedge clk);
        #1;
        check("hello done held", done_a, 1);
        check("hello idle wr_en", bus_a.mem_wr_en, 0);

        // Tap not in the table
        load_msg(0, 8'h55, 8'h01, 64, 64, 0);
        wr0 = wr_cnt_a;
        run_dut(0, cyc);
        check("nomatch cycles", cyc, 11);
        check("nomatch match_err", merr_a, 1);
        check("nomatch done", done_a, 1);
        check("nomatch writes", wr_cnt_a - wr0, 0);
        check("nomatch strip_ct", sct_a, 0);

        // 30 leading preambles saturate the strip counter
        fill_plain(30, 8'h42);
        plain[30] = 8'h41;
        load_msg(0, 8'hB8, 8'h01, 64, 64, 0);
        run_dut(0, cyc);
        check("sat cycles", cyc, 164);
        check("sat strip_ct", sct_a, 25);
        check("sat tap_idx", tidx_a, 3);
        check("sat dst0", mem_a[0], 8'h20);
        check("sat dst4", mem_a[4], 8'h20);
        check("sat dst5", mem_a[5], 8'h41);
        check("sat dst6", mem_a[6], 8'h42);
        check("sat dst38", mem_a[38], 8'h42);
        check("sat dst39", mem_a[39], 8'h20);

        // Duplicate candidate: lowest index wins
        taps_a[5*8 +: 8] = 8'hD4;
        set_hello();
        load_msg(0, 8'hD4, 8'h01, 64, 64, 0);
        run_dut(0, cyc);
        check("dup tap_idx", tidx_a, 1);
        check("dup match_err", merr_a, 0);
        check("dup dst0", mem_a[0], 8'h48);
        check("dup dst4", mem_a[4], 8'h6F);
        taps_a = c_DEFAULT_TAPS;

        // Abort during DECRYPT word 10, then a clean rerun
        load_msg(0, 8'hB8, 8'h01, 64, 64, 0);
        init_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 init_a = 1'b0;
        repeat (31) @(posedge clk);
        #1;
        check("abort running", done_a, 0);
        check("abort partial dst0", mem_a[0], 8'h48);
        wr0 = wr_cnt_a;
        init_a = 1'b1;
        @(posedge clk);
        #1;
        check("abort done", done_a, 0);
        check("abort tap_idx", tidx_a, 0);
        check("abort strip_ct", sct_a, 0);
        check("abort wr_en", bus_a.mem_wr_en, 0);
        check("abort addr", bus_a.mem_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort no writes", wr_cnt_a - wr0, 0);
        run_dut(0, cyc);
        check_hello("rerun", cyc);

        // In place, 16 words, tap FA
        fill_plain(9, 8'h2E);
        plain[9]  = 8'h48;
        plain[10] = 8'h69;
        plain[11] = 8'h21;
        load_msg(1, 8'hFA, 8'h01, 16, 0, 0);
        run_dut(1, cyc);
        check("inplace cycles", cyc, 52);
        check("inplace tap_idx", tidx_b, 6);
        check("inplace match_err", merr_b, 0);
        check("inplace strip_ct", sct_b, 9);
        check("inplace dst0", mem_b[0], 8'h48);
        check("inplace dst1", mem_b[1], 8'h69);
        check("inplace dst2", mem_b[2], 8'h21);
        check("inplace dst3", mem_b[3], 8'h2E);
        check("inplace dst6", mem_b[6], 8'h2E);
        check("inplace dst7", mem_b[7], 8'h20);
        check("inplace dst15", mem_b[15], 8'h20);
        check("inplace order", order_viol_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lfsr_decrypt_engine.md
Name: lfsr_decrypt_engine

Overview:
- Synthesizable, parametrised LFSR stream decryptor; successor to the behavioural lab-5 decrypt flow.
- Reads an encrypted message from data memory and identifies which candidate tap pattern produced it, using a known preamble character.
- Decrypts in place to a destination region, strips leading preamble characters, pads the tail, then raises done.
- Sits between the lab top level and the single-port data memory (dmem); owns the memory port while running.

Parameters:
- W, 8, data and LFSR width.
- ADDR_W, 8, memory address width.
- MSG_LEN, 64, words in the encrypted message.
- SRC_BASE, 64, address of ciphertext word 0.
- DST_BASE, 0, address of plaintext word 0.
- NUM_TAPS, 8, number of candidate tap patterns.
- PROBE_LEN, 8, LFSR steps checked during tap search (1..MSG_LEN-1).
- PREAMBLE, 8'h20, known leading plaintext character; also the pad character.
- CMP_MASK, 8'h7F, bits compared when stripping preamble.
- MAX_STRIP, 25, maximum leading characters stripped.

Ports:
- clk  in  1  clock.
- init  in  1  synchronous active-high reset; the run starts on the first cycle init is low after being high.
- taps_in  in  NUM_TAPS*W  candidate tap patterns; pattern k is bits [k*W +: W]. Sampled at start.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  W  write data.
- mem_rdata  in  W  read data; valid one cycle after mem_addr is presented.
- done  out  1  run complete; held until init.
- match_err  out  1  zero candidates matched; valid when done.
- tap_idx  out  $clog2(NUM_TAPS)  lowest matching candidate index; valid when done.
- strip_ct  out  $clog2(MAX_STRIP+1)  leading characters removed.

Behaviour:
- Reset (init=1) forces: state=IDLE, all outputs 0, candidate mask all ones, counters 0. Reset mid-run aborts with no further writes.
- LFSR step: next = {s[W-2:0], ^(s & tap)}.
- IDLE: on init falling, go to SEED.
- SEED: read SRC_BASE. Every trial LFSR is loaded with rdata ^ PREAMBLE.
- PROBE: for k=1..PROBE_LEN, read SRC_BASE+k. Step all NUM_TAPS trials in parallel. Clear mask bit j if trial_j != rdata ^ PREAMBLE.
- After PROBE:
  - If the mask is zero: match_err=1, go to DONE.
  - Otherwise: tap_idx = lowest set bit; reload the working LFSR with the seed.
- DECRYPT: two cycles per word, i=0..MSG_LEN-1.
  - Read cycle: fetch SRC_BASE+i.
  - Write cycle: p = rdata ^ lfsr, then step lfsr.
  - While in strip mode with (p ^ PREAMBLE) & CMP_MASK == 0 and strip_ct < MAX_STRIP: increment strip_ct and skip the write.
  - Otherwise: leave strip mode and write p to DST_BASE+wr_ptr, then increment wr_ptr.
- PAD: write PREAMBLE to DST_BASE+wr_ptr until wr_ptr == MSG_LEN, one word per cycle.
- DONE: done=1, mem_wr_en=0; hold until init.
- mem_wr_en is asserted only in DECRYPT write cycles and PAD. No read and write occur in the same cycle.
- Boundaries:
  - strip_ct saturates at MAX_STRIP.
  - An all-preamble message gives strip_ct = min(MSG_LEN, MAX_STRIP), and the remaining words are decrypted or padded.
  - Multiple candidates matching: the lowest index wins.
  - If SRC and DST regions overlap, reads always precede writes to the same address, because wr_ptr <= i.
  - init high during DONE returns to IDLE.
- Latency: 1+PROBE_LEN reads, plus 2*MSG_LEN cycles, plus strip_ct pad cycles, plus 2 overhead cycles.

Decomposition:
- Package lfsr_pkg:
  - state enum (IDLE, SEED, PROBE, DECRYPT, PAD, DONE).
  - function lfsr_step(s, tap).
  - default 8-entry tap table constant (E1, D4, C6, B8, B4, B2, FA, F3).
- One natural sub-module: lfsr_trial_bank, which holds NUM_TAPS parallel trial LFSRs plus the candidate mask, with load, step and compare inputs.
- The engine keeps the FSM, address counters and strip logic.

Test Plan:
- Default taps, message "Hello" plus padding, with 9 preambles, encrypted with tap B8 and seed 0x01 -> tap_idx=3, match_err=0, strip_ct=9, dst[0..4]=48 65 6C 6C 6F, dst[55..63]=20, done high after 1+8+128+9+2 cycles.
- Ciphertext from tap 0x55 (not in the table) -> match_err=1, done high, no mem_wr_en pulses.
- 30 leading preambles with MAX_STRIP=25 -> strip_ct=25, dst[0..4]=20, dst[5]=first non-space character.
- Duplicate tap: taps[1]=taps[5]=D4, message encrypted with D4 -> tap_idx=1.
- init pulsed high during DECRYPT at i=10 -> all outputs 0 within 1 cycle, no write after reset, clean rerun on next init fall gives results identical to an uninterrupted run.
- W=8, MSG_LEN=16, SRC_BASE=DST_BASE=0 (in place), tap FA -> correct plaintext, and every read precedes the overwrite of the same address.
